// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule emitting round keys 0..NUM_RND, one per beat; define AES_KEY_CACHE_EN for an 11-key replay cache
module aes_key_expand #(
  parameter int RND_SIZE = 128,
  parameter int WRD_SIZE = 32,
  parameter int NUM_RND = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RND_SIZE-1:0] i_key,
  input  logic                i_key_vld,
  output logic                o_key_rdy,
  output logic [RND_SIZE-1:0] o_rnd_key,
  output logic                o_rnd_key_vld,
  input  logic                i_rnd_rdy,
`ifdef AES_KEY_CACHE_EN
  input  logic                i_replay,
`endif
  output logic [3:0]          o_rnd_idx,
  output logic                o_lst_rnd
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  state_t state, state_nxt;
  logic [7:0] rcon, rcon_nxt, rcon_x2;
  logic [3:0] idx_nxt;
  logic [RND_SIZE-1:0] key_nxt, gen_key, step_key, first_key;
  logic [WRD_SIZE-1:0] w0, w1, w2, w3, t, w4, w5, w6, w7;
  logic rep_go;
  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  assign {w0, w1, w2, w3} = o_rnd_key;
  assign t = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rcon, 24'h0};
  assign w4 = w0 ^ t;
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;
  assign gen_key = {w4, w5, w6, w7};
  assign rcon_x2 = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  assign o_key_rdy = state == IDLE;
  assign o_rnd_key_vld = state == RUN;
  assign o_lst_rnd = o_rnd_key_vld && o_rnd_idx == 4'(NUM_RND);
`ifdef AES_KEY_CACHE_EN
  logic [RND_SIZE-1:0] key_mem [NUM_RND+1];
  logic cache_vld, rep;
  assign rep_go = i_replay && cache_vld;
  assign step_key = rep ? key_mem[o_rnd_idx + 4'd1] : gen_key;
  assign first_key = i_key_vld ? i_key : key_mem[0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_vld <= 1'b0;
      rep <= 1'b0;
    end else if (o_key_rdy && i_key_vld) begin
      cache_vld <= 1'b0;
      rep <= 1'b0;
      key_mem[0] <= i_key;
    end else if (o_key_rdy && rep_go) begin
      rep <= 1'b1;
    end else if (o_rnd_key_vld && i_rnd_rdy) begin
      if (o_lst_rnd) cache_vld <= 1'b1;
      else if (!rep) key_mem[o_rnd_idx + 4'd1] <= gen_key;
    end
  end
`else
  assign rep_go = 1'b0;
  assign step_key = gen_key;
  assign first_key = i_key;
`endif
  always_comb begin
    state_nxt = state;
    key_nxt = o_rnd_key;
    idx_nxt = o_rnd_idx;
    rcon_nxt = rcon;
    if (state == IDLE && (i_key_vld || rep_go)) begin
      state_nxt = RUN;
      key_nxt = first_key;
      idx_nxt = 4'd0;
      rcon_nxt = 8'h01;
    end else if (state == RUN && i_rnd_rdy) begin
      state_nxt = o_lst_rnd ? IDLE : RUN;
      key_nxt = o_lst_rnd ? o_rnd_key : step_key;
      idx_nxt = o_lst_rnd ? o_rnd_idx : o_rnd_idx + 4'd1;
      rcon_nxt = o_lst_rnd ? rcon : rcon_x2;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      o_rnd_key <= '0;
      o_rnd_idx <= 4'd0;
      rcon <= 8'h01;
    end else begin
      state <= state_nxt;
      o_rnd_key <= key_nxt;
      o_rnd_idx <= idx_nxt;
      rcon <= rcon_nxt;
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: randomized self-checking bench against a GF(2^8)-derived AES-128 key schedule model
module tb_aes_key_expand;
  logic clk = 0, rst_n = 0, i_key_vld = 0, i_rnd_rdy = 0;
  logic [127:0] i_key = '0, o_rnd_key;
  logic o_key_rdy, o_rnd_key_vld, o_lst_rnd;
  logic [3:0] o_rnd_idx;
  logic [7:0] sb_tab [256];
  logic [127:0] ref_ks [11], got [11], base [11];
  int checks = 0, failures = 0;
`ifdef AES_KEY_CACHE_EN
  logic i_replay = 0;
`endif
  aes_key_expand dut (
    .clk(clk), .rst_n(rst_n), .i_key(i_key), .i_key_vld(i_key_vld), .o_key_rdy(o_key_rdy),
    .o_rnd_key(o_rnd_key), .o_rnd_key_vld(o_rnd_key_vld), .i_rnd_rdy(i_rnd_rdy),
`ifdef AES_KEY_CACHE_EN
    .i_replay(i_replay),
`endif
    .o_rnd_idx(o_rnd_idx), .o_lst_rnd(o_lst_rnd)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] v = 0;
    for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) v = 8'(c);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction
  task automatic model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ref_ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask
  task automatic start(input logic [127:0] key);
    model(key);
    chk("key_rdy_idle", 128'(o_key_rdy), 128'd1);
    i_key = key;
    i_key_vld = 1;
    @(negedge clk);
    i_key_vld = 0;
  endtask
  task automatic stream(input bit stall, input bit poke);
    int beat = 0;
    int cyc = 0;
    while (beat <= 10 && cyc < 300) begin
      chk("vld", 128'(o_rnd_key_vld), 128'd1);
      chk("rnd_key", o_rnd_key, ref_ks[beat]);
      chk("rnd_idx", 128'(o_rnd_idx), 128'(beat));
      chk("lst_rnd", 128'(o_lst_rnd), 128'(beat == 10));
      chk("key_rdy_busy", 128'(o_key_rdy), 128'd0);
      got[beat] = o_rnd_key;
      i_rnd_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      i_key_vld = poke && beat == 3;
      i_key = {$urandom, $urandom, $urandom, $urandom};
      if (i_rnd_rdy) beat++;
      cyc++;
      @(negedge clk);
    end
    i_rnd_rdy = 0;
    i_key_vld = 0;
    chk("beat_count", 128'(beat), 128'd11);
    chk("vld_after", 128'(o_rnd_key_vld), 128'd0);
    chk("lst_after", 128'(o_lst_rnd), 128'd0);
    chk("key_rdy_after", 128'(o_key_rdy), 128'd1);
    chk("key_held", o_rnd_key, ref_ks[10]);
  endtask
  initial begin
    logic [127:0] k;
    for (int x = 0; x < 256; x++) sb_tab[x] = sbox_ref(8'(x));
    repeat (5) @(negedge clk);
    chk("rst_vld", 128'(o_rnd_key_vld), 128'd0);
    chk("rst_key", o_rnd_key, 128'd0);
    chk("rst_idx", 128'(o_rnd_idx), 128'd0);
    chk("rst_lst", 128'(o_lst_rnd), 128'd0);
    rst_n = 1;
    @(negedge clk);
    chk("rst_key_rdy", 128'(o_key_rdy), 128'd1);
`ifdef AES_KEY_CACHE_EN
    i_replay = 1;
    @(negedge clk);
    i_replay = 0;
    chk("replay_no_cache", 128'(o_rnd_key_vld), 128'd0);
`endif
    start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    stream(0, 0);
    chk("fips_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_idx9", got[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("fips_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    base = got;
`ifdef AES_KEY_CACHE_EN
    i_replay = 1;
    @(negedge clk);
    i_replay = 0;
    stream(1, 0);
    chk("replay_fips10", got[10], base[10]);
`endif
    start(128'h2b7e151628aed2a6abf7158809cf4f3c);
    stream(1, 0);
    for (int r = 0; r < 11; r++) chk("stall_vs_free", got[r], base[r]);
    start('0);
    stream(0, 0);
    chk("zero_idx1", got[1], 128'h62636363626363636263636362636363);
    for (int n = 0; n < 3; n++) begin
      start({$urandom, $urandom, $urandom, $urandom});
      stream(n[0], 1);
    end
    k = {$urandom, $urandom, $urandom, $urandom};
    start(k);
    for (int b = 0; b < 5; b++) begin
      chk("abort_key", o_rnd_key, ref_ks[b]);
      i_rnd_rdy = 1;
      @(negedge clk);
    end
    chk("abort_idx", 128'(o_rnd_idx), 128'd5);
    i_rnd_rdy = 0;
    rst_n = 0;
    @(negedge clk);
    chk("abort_vld", 128'(o_rnd_key_vld), 128'd0);
    chk("abort_key0", o_rnd_key, 128'd0);
    chk("abort_idx0", 128'(o_rnd_idx), 128'd0);
    rst_n = 1;
    @(negedge clk);
    start({$urandom, $urandom, $urandom, $urandom});
    stream(1, 0);
`ifdef AES_KEY_CACHE_EN
    base = ref_ks;
    k = {$urandom, $urandom, $urandom, $urandom};
    start(k);
    stream(0, 0);
    i_replay = 1;
    @(negedge clk);
    i_replay = 0;
    stream(1, 0);
    chk("replay_new_key", got[10] ^ base[10], ref_ks[10] ^ base[10]);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES-128 key-schedule generator that sits directly upstream of aes_round.
- Accepts one 128-bit cipher key and emits round keys 0..10, one per handshake beat.
- Each emitted key drives aes_round's i_rnd_key; the final key is flagged so the consumer can drive i_lst_rnd.
- Computes one round key per cycle with a single shared SubWord datapath (4 S-box lookups); no precomputed key table.

Parameters:
- RND_SIZE, 128, round key / cipher key width in bits (only 128 supported)
- WRD_SIZE, 32, key-schedule word width in bits
- NUM_RND, 10, number of rounds after the initial AddRoundKey; round keys emitted = NUM_RND+1

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- i_key  input  RND_SIZE  cipher key; word w0 = i_key[127:96]
- i_key_vld  input  1  cipher key valid
- o_key_rdy  output  1  block idle and able to accept a key
- o_rnd_key  output  RND_SIZE  current round key (registered)
- o_rnd_key_vld  output  1  o_rnd_key valid
- i_rnd_rdy  input  1  consumer accepts o_rnd_key this cycle
- o_rnd_idx  output  4  index of o_rnd_key, 0..NUM_RND
- o_lst_rnd  output  1  high when o_rnd_idx == NUM_RND and o_rnd_key_vld = 1

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset values, applied at the rising clk edge while rst_n = 0:
  - state = IDLE
  - o_rnd_key = 0, o_rnd_key_vld = 0, o_rnd_idx = 0, o_lst_rnd = 0
  - rcon register = 8'h01
- o_key_rdy = (state == IDLE). It is therefore 1 in the first cycle after reset releases.
- States:
  - IDLE: o_key_rdy = 1, o_rnd_key_vld = 0.
  - RUN: o_rnd_key_vld = 1.
- IDLE -> RUN, on i_key_vld & o_key_rdy at edge N:
  - o_rnd_key <= i_key, o_rnd_idx <= 0, rcon <= 8'h01.
  - Round key 0 is valid in cycle N+1 (latency 1).
- RUN, i_rnd_rdy = 0: o_rnd_key, o_rnd_idx and rcon hold stable (no change while vld & !rdy).
- RUN, i_rnd_rdy = 1 and o_rnd_idx < NUM_RND: load the next key in one cycle, o_rnd_idx += 1, rcon <= xtime(rcon).
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - RotWord(w3) = {w3[23:0], w3[31:24]}
  - w4 = w0 ^ t; w5 = w1 ^ w4; w6 = w2 ^ w5; w7 = w3 ^ w6
  - New o_rnd_key = {w4, w5, w6, w7}.
- RUN, i_rnd_rdy = 1 and o_rnd_idx == NUM_RND: go to IDLE, o_rnd_key_vld <= 0. o_rnd_key keeps its last value.
- xtime: {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00). Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- Throughput: 11 beats per key with i_rnd_rdy held at 1. The next key can be accepted in the cycle after the final beat.
- i_key_vld while in RUN is ignored (o_key_rdy = 0). The key is not latched.
- rst_n low mid-expansion: aborts at the next edge, returns to reset values, and no further beats are emitted.
- S-box: combinational FIPS-197 forward S-box, 4 instances. There is no pipelining inside the block.

Optional Feature:
- Macro: AES_KEY_CACHE_EN.
- When defined:
  - An 11 x 128 register file stores every round key as it is generated.
  - Adds an input port i_replay (1 bit), accepted only in IDLE once a full expansion has completed since reset.
  - i_replay re-emits keys 0..10 from the cache with the same handshake, without recomputation.
  - A new i_key_vld invalidates the cache. If i_key_vld and i_replay are asserted together, i_key_vld wins.
  - i_replay with no valid cache is ignored.
- When not defined: no i_replay port and no storage; behaviour is exactly as above.

Test Plan:
- Reset: rst_n = 0 for 5 cycles -> o_rnd_key_vld = 0, o_rnd_key = 0, o_rnd_idx = 0. o_key_rdy = 1 in the first cycle after release.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with i_rnd_rdy = 1:
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx9 = ac7766f319fadc2128d12941575c006e (exercises rcon 1B)
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with o_lst_rnd = 1 only on this beat
  - 11 beats total, then o_key_rdy = 1.
- All-zero key -> idx1 = 62636363626363636263636362636363. Key-to-first-beat latency is exactly 1 cycle.
- Backpressure: toggle i_rnd_rdy pseudo-randomly -> o_rnd_key and o_rnd_idx stay stable while vld & !rdy. The key sequence is identical to the unstalled run.
- i_key_vld pulsed with a different key during RUN -> ignored, and the sequence continues. rst_n low at idx 5 -> vld = 0 next cycle, then a fresh key expands correctly.
- With AES_KEY_CACHE_EN: expand the FIPS key, then pulse i_replay -> identical 11 keys. A new key followed by i_replay -> the new key's schedule is replayed, not the old one.
